// File: rtl/evm_ballot_frontend_if.sv
// Button, core-status and strobe bundle between the ballot frontend and its environment.
interface evm_ballot_frontend_if;
    logic btn_c1;
    logic btn_c2;
    logic btn_c3;
    logic btn_ready;
    logic btn_done;
    logic voting_in_progress;
    logic vote_candidate_1;
    logic vote_candidate_2;
    logic vote_candidate_3;
    logic candidate_ready;
    logic voting_session_done;
    logic ballot_armed;
    logic multi_press_err;
    logic ballot_aborted;

    modport master (
        output btn_c1, btn_c2, btn_c3, btn_ready, btn_done, voting_in_progress,
        input  vote_candidate_1, vote_candidate_2, vote_candidate_3, candidate_ready,
               voting_session_done, ballot_armed, multi_press_err, ballot_aborted
    );

    modport slave (
        input  btn_c1, btn_c2, btn_c3, btn_ready, btn_done, voting_in_progress,
        output vote_candidate_1, vote_candidate_2, vote_candidate_3, candidate_ready,
               voting_session_done, ballot_armed, multi_press_err, ballot_aborted
    );
endinterface

// File: rtl/evm_ballot_frontend.sv
// Synchronise and debounce EVM push-buttons, then run the one-vote-per-ballot FSM
// that produces the clean strobes consumed by the voting core.
//
// state  | meaning
// IDLE   | no ballot open, waiting for presiding officer
// ARMED  | ballot issued, waiting for exactly one candidate press
// LOCKED | vote cast, waiting for all candidate buttons to be released
// DONE   | session closed, absorbing until reset
module evm_ballot_frontend #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    evm_ballot_frontend_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOCKED, S_DONE} state_t;

    // bit order: c1, c2, c3, ready, done
    logic [4:0]    raw;
    logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [4:0]    stable_q, stable_d, prev_q, prev_d;
    logic [4:0]    evt_q, evt_d, qual_q, qual_d;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];
    logic [1:0]    init_q, init_d;

    state_t        state_q, state_d;
    logic          vip_seen_q, vip_seen_d;
    logic [2:0]    vote_q, vote_d;
    logic          ready_q, ready_d, err_q, err_d, abort_q, abort_d;
    logic          armed_q, armed_d, done_q, done_d;
    logic [2:0]    cand;
    logic          one_hot, multi;

    assign raw = {bus.btn_done, bus.btn_ready, bus.btn_c3, bus.btn_c2, bus.btn_c1};

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        prev_d   = stable_q;
        evt_d    = stable_q & ~prev_q & qual_q;
        init_d   = (init_q == 2'd2) ? init_q : init_q + 2'd1;
        // A button only generates events once it has been seen released; buttons
        // held through reset therefore never fire on reset release.
        qual_d   = qual_q | ({5{init_q == 2'd2}} & ~sync2_q & ~stable_q);
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = ~stable_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign cand    = evt_q[2:0];
    assign one_hot = $onehot(cand);
    assign multi   = (cand != 3'b000) && !one_hot;

    always_comb begin
        state_d    = state_q;
        vip_seen_d = vip_seen_q;
        vote_d     = 3'b000;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        abort_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                vip_seen_d = 1'b0;
                if (evt_q[3]) begin
                    state_d = S_ARMED;
                    ready_d = 1'b1;
                end else if (evt_q[4]) begin
                    state_d = S_DONE;
                end
            end
            S_ARMED: begin
                if (bus.voting_in_progress) vip_seen_d = 1'b1;
                if (one_hot) begin
                    vote_d  = cand;
                    state_d = S_LOCKED;
                end else if (vip_seen_q && !bus.voting_in_progress) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (multi) begin
                    err_d = 1'b1;
                end
            end
            S_LOCKED: begin
                if (stable_q[2:0] == 3'b000) state_d = S_IDLE;
            end
            default: state_d = S_DONE;
        endcase
        armed_d = (state_d == S_ARMED);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            prev_q     <= '0;
            evt_q      <= '0;
            qual_q     <= '0;
            cnt_q      <= '{default: '0};
            init_q     <= '0;
            state_q    <= S_IDLE;
            vip_seen_q <= 1'b0;
            vote_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            prev_q     <= prev_d;
            evt_q      <= evt_d;
            qual_q     <= qual_d;
            cnt_q      <= cnt_d;
            init_q     <= init_d;
            state_q    <= state_d;
            vip_seen_q <= vip_seen_d;
            vote_q     <= vote_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
        end
    end

    assign bus.vote_candidate_1    = vote_q[0];
    assign bus.vote_candidate_2    = vote_q[1];
    assign bus.vote_candidate_3    = vote_q[2];
    assign bus.candidate_ready     = ready_q;
    assign bus.multi_press_err     = err_q;
    assign bus.ballot_aborted      = abort_q;
    assign bus.ballot_armed        = armed_q;
    assign bus.voting_session_done = done_q;
endmodule
